fetch_stage: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the processor core's decode logic.
- Owns the PC and drives the 12-bit word address into the synchronous imem, which has one-cycle read latency.
- Presents each instruction to decode with its PC under a valid/stall handshake, and accepts branch/jump redirects.
- Keeps saturating fetch and stall performance counters for the test outputs.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_stage_sat_counter.sv | 28 ++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// default geometry and the saturation limit of the performance counters.
package fetch_pkg;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned DEF_ADDR_WIDTH = 12;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_RESET_PC   = 0;
   localparam int unsigned CNT_WIDTH      = 32;
   localparam logic [CNT_WIDTH-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; cleared only by reset.
module sat_counter #(
   parameter int unsigned     WIDTH = 32,
   parameter logic [WIDTH-1:0] MAX  = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != MAX)) count_d = count_q + WIDTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge; reset is asynchronous and active-low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, drives the synchronous imem and hands each
// instruction to decode under a valid/stall handshake with redirect support.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_enable,
   input  logic                  stall_in,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0] imem_q,
   output logic                  fd_valid,
   output logic [DATA_WIDTH-1:0] fd_instr,
   output logic [ADDR_WIDTH-1:0] fd_pc,
   output logic [ADDR_WIDTH-1:0] fd_pc_plus1,
   output logic [CNT_WIDTH-1:0]  fetch_count,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_f_q, pc_f_d;
   logic [ADDR_WIDTH-1:0] pc_plus1;
   logic                  accept;

   assign pc_plus1 = pc_f_q + ADDR_WIDTH'(1);
   assign fd_valid = (state_q == ST_RUN) && !redirect_valid;
   assign accept   = fd_valid && !stall_in;

   // pc_f always tracks the address issued this cycle, so imem_q next cycle is mem[pc_f].
   always_comb begin
      state_d = state_q;
      pc_f_d  = pc_f_q;
      if (redirect_valid) pc_f_d = redirect_target;
      else if (accept)    pc_f_d = pc_plus1;

      unique case (state_q)
         ST_WAIT: if (fetch_enable) state_d = ST_RUN;
         ST_RUN:  if (accept && !fetch_enable) state_d = ST_WAIT;
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
         pc_f_q  <= RESET_ADDR;
      end else begin
         state_q <= state_d;
         pc_f_q  <= pc_f_d;
      end
   end

   // While reset is held the imem must see the reset PC regardless of redirects.
   assign imem_address = reset ? pc_f_d : RESET_ADDR;
   assign fd_instr     = imem_q;
   assign fd_pc        = pc_f_q;
   assign fd_pc_plus1  = pc_plus1;

   sat_counter #(.WIDTH(CNT_WIDTH), .MAX(COUNT_MAX)) u_fetch_cnt (
      .clk_i   (clock),
      .rst_ni  (reset),
      .inc_i   (accept),
      .count_o (fetch_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH), .MAX(COUNT_MAX)) u_stall_cnt (
      .clk_i   (clock),
      .rst_ni  (reset),
      .inc_i   (fd_valid && stall_in),
      .count_o (stall_count)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// reset/saturation sequences, then random stimulus against a transaction model.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_enable, stall_in, redirect_valid;
   logic [11:0] redirect_target;
   logic [11:0] imem_address;
   logic [31:0] imem_q;
   logic        fd_valid;
   logic [31:0] fd_instr;
   logic [11:0] fd_pc, fd_pc_plus1;
   logic [31:0] fetch_count, stall_count;

   logic        cnt_rst_n, cnt_inc;
   logic [3:0]  cnt_val;

   logic [31:0] mem [4096];
   int          tests = 0;
   int          fails = 0;

   always #5 clock = ~clock;
   always @(posedge clock) imem_q <= mem[imem_address];

   fetch_stage dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_enable    (fetch_enable),
      .stall_in        (stall_in),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_address    (imem_address),
      .imem_q          (imem_q),
      .fd_valid        (fd_valid),
      .fd_instr        (fd_instr),
      .fd_pc           (fd_pc),
      .fd_pc_plus1     (fd_pc_plus1),
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
   );

   sat_counter #(.WIDTH(4)) u_small_cnt (
      .clk_i   (clock),
      .rst_ni  (cnt_rst_n),
      .inc_i   (cnt_inc),
      .count_o (cnt_val)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          fe, st, rd;
      logic [11:0] tgt;
      bit          valid;
      logic [11:0] pc, addr;
      int          fc, sc;
   } vec_t;

   function automatic vec_t mk(bit fe, bit st, bit rd, int tgt, bit valid, int pc, int addr,
                               int fc, int sc);
      vec_t v;
      v.fe = fe; v.st = st; v.rd = rd; v.tgt = 12'(tgt);
      v.valid = valid; v.pc = 12'(pc); v.addr = 12'(addr); v.fc = fc; v.sc = sc;
      return v;
   endfunction

   vec_t vt[21];

   initial begin
      bit  m_run;
      int  m_pc, m_fc, m_sc;
      bit  exp_valid;

      for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 100);
      // fe st rd tgt | valid pc addr fc sc
      vt[0]  = mk(1,0,0,0,     1,0,1,0,0);
      vt[1]  = mk(1,0,0,0,     1,1,2,1,0);
      vt[2]  = mk(1,0,0,0,     1,2,3,2,0);
      vt[3]  = mk(1,0,0,0,     1,3,4,3,0);
      vt[4]  = mk(1,0,0,0,     1,4,5,4,0);
      vt[5]  = mk(1,1,0,0,     1,5,5,5,0);
      vt[6]  = mk(1,1,0,0,     1,5,5,5,1);
      vt[7]  = mk(1,1,0,0,     1,5,5,5,2);
      vt[8]  = mk(1,0,0,0,     1,5,6,5,3);
      vt[9]  = mk(1,0,0,0,     1,6,7,6,3);
      vt[10] = mk(1,1,1,'h200, 0,7,'h200,7,3);
      vt[11] = mk(1,0,0,0,     1,'h200,'h201,7,3);
      vt[12] = mk(1,0,1,4095,  0,'h201,4095,8,3);
      vt[13] = mk(1,0,0,0,     1,4095,0,8,3);
      vt[14] = mk(1,0,0,0,     1,0,1,9,3);
      vt[15] = mk(1,0,0,0,     1,1,2,10,3);
      vt[16] = mk(0,0,0,0,     1,2,3,11,3);
      vt[17] = mk(0,0,0,0,     0,3,3,12,3);
      vt[18] = mk(1,0,0,0,     0,3,3,12,3);
      vt[19] = mk(1,0,0,0,     1,3,4,12,3);
      vt[20] = mk(1,0,0,0,     1,4,5,13,3);

      cnt_rst_n = 1'b0; cnt_inc = 1'b0;
      reset = 1'b0; fetch_enable = 1'b1; stall_in = 1'b0;
      redirect_valid = 1'b0; redirect_target = '0;

      #12;
      check("reset fd_valid", 32'(fd_valid), 0);
      check("reset imem_address", 32'(imem_address), 0);
      check("reset fetch_count", fetch_count, 0);
      check("reset stall_count", stall_count, 0);
      #10 reset = 1'b1;

      foreach (vt[i]) begin
         @(posedge clock); #1;
         fetch_enable = vt[i].fe; stall_in = vt[i].st;
         redirect_valid = vt[i].rd; redirect_target = vt[i].tgt;
         #1;
         check($sformatf("vec%0d fd_valid", i), 32'(fd_valid), 32'(vt[i].valid));
         check($sformatf("vec%0d fd_pc", i), 32'(fd_pc), 32'(vt[i].pc));
         check($sformatf("vec%0d fd_pc_plus1", i), 32'(fd_pc_plus1), 32'((vt[i].pc + 1) % 4096));
         check($sformatf("vec%0d imem_address", i), 32'(imem_address), 32'(vt[i].addr));
         check($sformatf("vec%0d fetch_count", i), fetch_count, 32'(vt[i].fc));
         check($sformatf("vec%0d stall_count", i), stall_count, 32'(vt[i].sc));
         if (vt[i].valid) check($sformatf("vec%0d fd_instr", i), fd_instr, 32'(vt[i].pc) + 100);
      end

      // Stream up to pc 20, then assert reset mid-cycle.
      fetch_enable = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0;
      repeat (16) @(posedge clock);
      #1;
      check("stream fd_pc", 32'(fd_pc), 20);
      check("stream fetch_count", fetch_count, 29);
      #2 reset = 1'b0;
      #1;
      check("midreset fd_valid", 32'(fd_valid), 0);
      check("midreset fetch_count", fetch_count, 0);
      check("midreset stall_count", stall_count, 0);
      check("midreset imem_address", 32'(imem_address), 0);
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;
      check("restart fd_valid", 32'(fd_valid), 1);
      check("restart fd_pc", 32'(fd_pc), 0);
      check("restart fd_instr", fd_instr, 100);

      // Saturation on a narrow instance of the counter.
      @(negedge clock) cnt_rst_n = 1'b1; cnt_inc = 1'b1;
      repeat (10) @(posedge clock);
      #1 check("satcnt ten", 32'(cnt_val), 10);
      repeat (10) @(posedge clock);
      #1 check("satcnt saturated", 32'(cnt_val), 15);
      cnt_inc = 1'b0;

      // Random phase against a transaction-level model.
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      @(negedge clock);
      fetch_enable = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; reset = 1'b0;
      @(negedge clock) reset = 1'b1;
      m_run = 1'b0; m_pc = 0; m_fc = 0; m_sc = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         fetch_enable    = ($urandom_range(0, 7) != 0);
         stall_in        = ($urandom_range(0, 3) == 0);
         redirect_valid  = ($urandom_range(0, 7) == 0);
         redirect_target = 12'($urandom);
         #1;
         exp_valid = m_run && !redirect_valid;
         check($sformatf("rnd%0d fd_valid", c), 32'(fd_valid), 32'(exp_valid));
         check($sformatf("rnd%0d fd_pc", c), 32'(fd_pc), 32'(m_pc));
         check($sformatf("rnd%0d fd_pc_plus1", c), 32'(fd_pc_plus1), 32'((m_pc + 1) % 4096));
         check($sformatf("rnd%0d fetch_count", c), fetch_count, 32'(m_fc));
         check($sformatf("rnd%0d stall_count", c), stall_count, 32'(m_sc));
         if (exp_valid) check($sformatf("rnd%0d fd_instr", c), fd_instr, mem[m_pc]);

         if (!m_run) begin
            if (redirect_valid) m_pc = int'(redirect_target);
            m_run = fetch_enable;
         end else if (redirect_valid) begin
            m_pc = int'(redirect_target);
         end else if (stall_in) begin
            m_sc++;
         end else begin
            m_fc++;
            m_pc = (m_pc + 1) % 4096;
            m_run = fetch_enable;
         end
         check($sformatf("rnd%0d imem_address", c), 32'(imem_address), 32'(m_pc));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
